// File: rtl/sr_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply and
// restoring divide, one bit per cycle, with a one-cycle path for div-by-zero/overflow.
module sr_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_t;

    state_t            state_q, state_d;
    op_t               op_q, op_d, op_in;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;

    logic              a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag, fast_res;

    always_comb begin
        op_in    = op_t'(op);
        a_signed = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_signed = op_in inside {OP_MULH, OP_DIV, OP_REM};
        a_neg    = a_signed & srcA[XLEN-1];
        b_neg    = b_signed & srcB[XLEN-1];
        a_mag    = a_neg ? -srcA : srcA;
        b_mag    = b_neg ? -srcB : srcB;
        div_zero = op[2] && (srcB == '0);
        div_ovf  = (op_in == OP_DIV || op_in == OP_REM) &&
                   (srcA == {1'b1, {(XLEN-1){1'b0}}}) && (srcB == '1);
        // op[1] separates REM/REMU from DIV/DIVU
        if (div_zero) fast_res = op[1] ? srcA : '1;
        else          fast_res = op[1] ? '0 : srcA;
    end

    // acc holds {hi, multiplier} for multiply and {remainder, quotient} for divide
    logic [XLEN:0]     mul_sum, rem_sh, diff;
    logic [2*XLEN-1:0] acc_step, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, run_res;
    logic              is_div_q;

    always_comb begin
        is_div_q = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        diff     = rem_sh - {1'b0, b_q};
        if (!is_div_q)
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        else if (diff[XLEN])
            acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
            acc_step = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        prod_fix = neg_q ? -acc_step : acc_step;
        quo_fix  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem_fix  = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        run_res  = '0;
        case (op_q)
            OP_MUL:                       run_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: run_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              run_res = quo_fix;
            OP_REM, OP_REMU:              run_res = rem_fix;
            default:                      run_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (div_zero || div_ovf) begin
                        state_d  = DONE;
                        result_d = fast_res;
                    end else begin
                        state_d = RUN;
                        op_d    = op_in;
                        a_d     = a_mag;
                        b_d     = b_mag;
                        neg_d   = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
                        cnt_d   = CW'(XLEN - 1);
                        acc_d   = {{XLEN{1'b0}}, op[2] ? a_mag : b_mag};
                    end
                end
            end
            RUN: begin
                acc_d = acc_step;
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    result_d = run_res;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_sr_muldiv.sv
// Bench for sr_muldiv: directed and random operations on XLEN=32 and XLEN=8
// instances against an arithmetic reference model.
module tb_sr_muldiv;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start32, flush32, busy32, done32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, res32;
    logic        start8, flush8, busy8, done8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, res8;

    int vectors     = 0;
    int miscompares = 0;

    sr_muldiv #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .flush(flush32), .op(op32),
        .srcA(a32), .srcB(b32), .busy(busy32), .done(done32), .result(res32)
    );

    sr_muldiv #(.XLEN(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .flush(flush8), .op(op8),
        .srcA(a8), .srcB(b8), .busy(busy8), .done(done8), .result(res8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input int xl, input logic [2:0] o,
                                              input logic [31:0] a, input logic [31:0] b);
        longint unsigned m  = (64'd1 << xl) - 64'd1;
        longint unsigned au = {32'd0, a} & m;
        longint unsigned bu = {32'd0, b} & m;
        longint sa = a[xl-1] ? longint'(au) - (longint'(1) << xl) : longint'(au);
        longint sb = b[xl-1] ? longint'(bu) - (longint'(1) << xl) : longint'(bu);
        longint min_v = -(longint'(1) << (xl - 1));
        longint p;
        longint unsigned pu;
        case (o)
            3'b000: begin p = sa * sb;            return 32'(p & longint'(m)); end
            3'b001: begin p = sa * sb;            return 32'((p >>> xl) & longint'(m)); end
            3'b010: begin p = sa * longint'(bu);  return 32'((p >>> xl) & longint'(m)); end
            3'b011: begin pu = au * bu;           return 32'((pu >> xl) & m); end
            3'b100: begin
                if (bu == 0) return 32'(m);
                if (sa == min_v && sb == -1) return 32'(au);
                return 32'((sa / sb) & longint'(m));
            end
            3'b101: return (bu == 0) ? 32'(m) : 32'(au / bu);
            3'b110: begin
                if (bu == 0) return 32'(au);
                if (sa == min_v && sb == -1) return 32'd0;
                return 32'((sa % sb) & longint'(m));
            end
            default: return (bu == 0) ? 32'(au) : 32'(au % bu);
        endcase
    endfunction

    function automatic bit is_fast(input int xl, input logic [2:0] o,
                                   input logic [31:0] a, input logic [31:0] b);
        logic [31:0] m = (xl == 32) ? 32'hFFFF_FFFF : ((32'd1 << xl) - 32'd1);
        if (!o[2]) return 1'b0;
        if ((b & m) == 32'd0) return 1'b1;
        return (o == 3'b100 || o == 3'b110) && ((a & m) == (32'd1 << (xl - 1))) && ((b & m) == m);
    endfunction

    task automatic set_ops(input bit w8, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (w8) begin op8 = o; a8 = a[7:0]; b8 = b[7:0]; end
        else    begin op32 = o; a32 = a; b32 = b; end
    endtask

    task automatic set_ctl(input bit w8, input logic s, input logic f);
        if (w8) begin start8 = s; flush8 = f; end
        else    begin start32 = s; flush32 = f; end
    endtask

    function automatic logic cur_done(input bit w8);
        return w8 ? done8 : done32;
    endfunction

    function automatic logic cur_busy(input bit w8);
        return w8 ? busy8 : busy32;
    endfunction

    function automatic logic [31:0] cur_res(input bit w8);
        return w8 ? {24'd0, res8} : res32;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // inj_kind: 0 none, 1 foreign start during RUN, 2 flush, 3 async reset pulse
    task automatic do_op(input bit w8, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int inj_kind, input int inj_cyc,
                         output logic [31:0] r, output int lat, output int busyc, output bit overlap);
        set_ops(w8, o, a, b);
        set_ctl(w8, 1'b1, 1'b0);
        tick();
        set_ctl(w8, 1'b0, 1'b0);
        lat = 0;
        busyc = 0;
        overlap = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            if (cur_busy(w8) && cur_done(w8)) overlap = 1'b1;
            if (cur_done(w8)) begin
                lat = n;
                break;
            end
            if (cur_busy(w8)) busyc++;
            if (n == inj_cyc && inj_kind == 1) begin
                set_ops(w8, 3'b101, $urandom, 32'd3);
                set_ctl(w8, 1'b1, 1'b0);
            end else if (n == inj_cyc && inj_kind == 2) begin
                set_ctl(w8, 1'b0, 1'b1);
            end else if (n == inj_cyc && inj_kind == 3) begin
                rst_n = 1'b0;
                #1;
                check("async_rst_result", cur_res(w8), 32'd0);
                check("async_rst_busy", {31'd0, cur_busy(w8)}, 32'd0);
                check("async_rst_done", {31'd0, cur_done(w8)}, 32'd0);
                rst_n = 1'b1;
            end else begin
                set_ctl(w8, 1'b0, 1'b0);
            end
            tick();
        end
        r = cur_res(w8);
    endtask

    task automatic gen(input int xl, output logic [31:0] a, output logic [31:0] b);
        logic [31:0] m = (xl == 32) ? 32'hFFFF_FFFF : ((32'd1 << xl) - 32'd1);
        int sel = $urandom_range(0, 9);
        a = $urandom & m;
        b = $urandom & m;
        if (sel == 0) b = 32'd0;
        if (sel == 1) begin a = 32'd1 << (xl - 1); b = m; end
        if (sel == 2) b = m;
        if (sel == 3) a = 32'd1 << (xl - 1);
    endtask

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    vec_t dir32 [12] = '{
        '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
        '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
        '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
        '{3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC},
        '{3'b111, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001},
        '{3'b100, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF},
        '{3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005},
        '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}
    };

    initial begin
        logic [31:0] r, r2, prev, a, b;
        logic [2:0]  o;
        int          lat, bc, elat;
        bit          ov;

        rst_n = 1'b0;
        set_ctl(1'b0, 1'b0, 1'b0);
        set_ctl(1'b1, 1'b0, 1'b0);
        set_ops(1'b0, 3'b000, 32'd0, 32'd0);
        set_ops(1'b1, 3'b000, 32'd0, 32'd0);
        repeat (2) tick();
        check("rst_result32", res32, 32'd0);
        check("rst_busy32", {31'd0, busy32}, 32'd0);
        check("rst_done32", {31'd0, done32}, 32'd0);
        check("rst_result8", {24'd0, res8}, 32'd0);
        check("rst_busy8", {31'd0, busy8}, 32'd0);
        check("rst_done8", {31'd0, done8}, 32'd0);
        rst_n = 1'b1;
        tick();

        foreach (dir32[i]) begin
            elat = is_fast(32, dir32[i].op, dir32[i].a, dir32[i].b) ? 1 : 33;
            do_op(1'b0, dir32[i].op, dir32[i].a, dir32[i].b, 0, 0, r, lat, bc, ov);
            check($sformatf("dir32_%0d_result", i), r, dir32[i].e);
            check($sformatf("dir32_%0d_latency", i), 32'(lat), 32'(elat));
            check($sformatf("dir32_%0d_busy_cycles", i), 32'(bc), (elat == 1) ? 32'd0 : 32'd32);
            check($sformatf("dir32_%0d_busy_and_done", i), {31'd0, ov}, 32'd0);
            tick();
            check($sformatf("dir32_%0d_done_pulse", i), {31'd0, done32}, 32'd0);
            check($sformatf("dir32_%0d_result_hold", i), res32, dir32[i].e);
        end

        // start in RUN is ignored and not queued
        do_op(1'b0, 3'b000, 32'd1234567, 32'd89, 1, 10, r, lat, bc, ov);
        check("run_start_result", r, ref_model(32, 3'b000, 32'd1234567, 32'd89));
        check("run_start_latency", 32'(lat), 32'd33);
        tick();
        check("run_start_no_queue_busy", {31'd0, busy32}, 32'd0);
        check("run_start_no_queue_done", {31'd0, done32}, 32'd0);

        // flush mid-RUN
        prev = res32;
        do_op(1'b0, 3'b101, $urandom, $urandom | 32'd1, 2, 5, r, lat, bc, ov);
        check("flush_no_done", 32'(lat), 32'd0);
        check("flush_result_kept", r, prev);
        check("flush_idle", {31'd0, busy32}, 32'd0);

        // async reset mid-RUN
        do_op(1'b0, 3'b011, $urandom, $urandom, 3, 7, r, lat, bc, ov);
        check("reset_no_done", 32'(lat), 32'd0);
        check("reset_result_zero", r, 32'd0);

        // back-to-back: start during DONE
        do_op(1'b0, 3'b111, 32'd1000, 32'd7, 0, 0, r, lat, bc, ov);
        check("b2b_first_result", r, 32'd6);
        do_op(1'b0, 3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 0, 0, r2, lat, bc, ov);
        check("b2b_second_result", r2, 32'hFFFF_FFFF);
        check("b2b_second_latency", 32'(lat), 32'd33);
        do_op(1'b0, 3'b100, 32'd5, 32'd0, 0, 0, r, lat, bc, ov);
        check("b2b_fast_latency", 32'(lat), 32'd1);
        do_op(1'b0, 3'b000, 32'd12, 32'd11, 0, 0, r, lat, bc, ov);
        check("b2b_after_fast_result", r, 32'd132);
        check("b2b_after_fast_latency", 32'(lat), 32'd33);

        // flush wins over start in the DONE cycle
        set_ops(1'b0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        set_ctl(1'b0, 1'b1, 1'b1);
        tick();
        set_ctl(1'b0, 1'b0, 1'b0);
        check("flush_done_idle_busy", {31'd0, busy32}, 32'd0);
        check("flush_done_idle_done", {31'd0, done32}, 32'd0);
        check("flush_done_result", res32, 32'd132);
        tick();
        check("flush_done_not_started", {31'd0, busy32}, 32'd0);

        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            gen(32, a, b);
            elat = is_fast(32, o, a, b) ? 1 : 33;
            do_op(1'b0, o, a, b, 0, 0, r, lat, bc, ov);
            check($sformatf("rnd32_%0d_op%0d_result", i, o), r, ref_model(32, o, a, b));
            check($sformatf("rnd32_%0d_latency", i), 32'(lat), 32'(elat));
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();

        do_op(1'b1, 3'b011, 32'hFF, 32'hFF, 0, 0, r, lat, bc, ov);
        check("x8_mulhu_result", r, 32'h0000_00FE);
        check("x8_mulhu_latency", 32'(lat), 32'd9);
        check("x8_mulhu_busy_cycles", 32'(bc), 32'd8);
        tick();
        do_op(1'b1, 3'b100, 32'h80, 32'hFF, 0, 0, r, lat, bc, ov);
        check("x8_div_ovf_result", r, 32'h0000_0080);
        check("x8_div_ovf_latency", 32'(lat), 32'd1);
        check("x8_div_ovf_busy_cycles", 32'(bc), 32'd0);
        tick();

        for (int i = 0; i < 300; i++) begin
            o = 3'($urandom_range(0, 7));
            gen(8, a, b);
            elat = is_fast(8, o, a, b) ? 1 : 9;
            do_op(1'b1, o, a, b, 0, 0, r, lat, bc, ov);
            check($sformatf("rnd8_%0d_op%0d_a%02h_b%02h", i, o, a[7:0], b[7:0]), r, ref_model(8, o, a, b));
            check($sformatf("rnd8_%0d_latency", i), 32'(lat), 32'(elat));
            check($sformatf("rnd8_%0d_busy_and_done", i), {31'd0, ov}, 32'd0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sr_muldiv.md
# sr_muldiv

Parametrised multi-cycle integer multiply/divide unit implementing the RISC-V M-extension operations for a core datapath of width XLEN. It sits beside the single-cycle ALU and is driven by the control unit through a start/busy/done handshake. While the unit computes, the core stalls; when done pulses, the result is written to the register file. Multiplication uses iterative shift-add and division uses restoring division, one bit per cycle, with sign pre/post-correction and a one-cycle fast path for RISC-V special cases.

## Interface
- XLEN, 32, operand/result width; legal values are ≥ 4 and even.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- flush  in  1  synchronous abort; returns the unit to IDLE and suppresses done.
- op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- srcA  in  XLEN  multiplicand/dividend; latched when start is accepted.
- srcB  in  XLEN  multiplier/divisor; latched when start is accepted.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; result is valid while done=1.
- result  out  XLEN  registered result; holds its last value until the next done.

## Operation
- States: IDLE, RUN, DONE.
- Transitions:
  - IDLE→RUN on start, or IDLE→DONE on start when a fast-path case applies.
  - RUN stays in RUN while the iteration counter is nonzero; RUN→DONE after the final iteration.
  - DONE→RUN or DONE→DONE on start, allowing back-to-back operations; otherwise DONE→IDLE.
  - Any state→IDLE on flush. flush has priority over start.
- Latching on an accepted start:
  - op, the operand magnitudes, the result sign flag and the counter are latched.
  - The counter loads XLEN-1.
  - Later changes to srcA, srcB or op have no effect on the running operation.
- Signedness:
  - srcA is signed for MULH, MULHSU, DIV and REM.
  - srcB is signed for MULH, DIV and REM.
  - MUL is sign-agnostic because it produces the low half only.
- Multiplication:
  - 2·XLEN-bit accumulator, one partial product per cycle.
  - Product sign = sign(a) XOR sign(b), using only the operands treated as signed.
  - MUL returns bits [XLEN-1:0]; the MULH variants return bits [2XLEN-1:XLEN] of the signed-corrected product.
- Division:
  - XLEN-bit unsigned restoring division on magnitudes.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - DIVU and REMU use no correction.
- Fast path, detected at start with no RUN cycles:
  - Divisor = 0: quotient is all ones, remainder = srcA.
  - Signed overflow (srcA = −2^(XLEN−1), srcB = −1): DIV returns srcA, REM returns 0.
- start while in RUN is ignored; there is no queueing.
- The result register is written only on entry to DONE.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=0, counter=0.
- Normal latency, with start accepted at edge t:
  - RUN iterations happen on edges t+1 … t+XLEN.
  - done=1 between edges t+XLEN and t+XLEN+1.
  - Total latency is XLEN+1 cycles.
- Fast-path latency: done=1 between edges t and t+1.
- busy is 0 in the DONE cycle; done and busy are never both 1.
- Throughput: one operation per XLEN+1 cycles, because start during DONE is accepted on the same edge.
- flush or rst_n during RUN: no done pulse follows, and result keeps its previous value; rst_n clears result to 0.
- flush asserted in the DONE cycle: done is still high that cycle because it is already registered, and the unit goes to IDLE next.

## Test plan
- MUL 7×−3 (0xFFFFFFFD) → result 0xFFFFFFEB; done exactly 33 cycles after the start cycle; busy high for 32 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Division:
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
  - REMU 0xFFFFFFF9/2 → 1.
- Fast path:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
  - Every fast-path case gives done on the cycle after start, with busy never set.
- Control:
  - A start pulse in RUN cycle 10 with different operands is ignored.
  - flush in RUN cycle 5 → no done, result unchanged.
  - rst_n low mid-RUN → result=0 and state IDLE immediately.
  - start in the DONE cycle → the second done follows 33 cycles later.
- XLEN=8 instance:
  - MULHU 0xFF×0xFF → 0xFE, done after 9 cycles.
  - DIV 0x80/0xFF → 0x80.
  - Randomised compare against a reference model for all 8 ops.
